instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch unit: one-cycle-latency IMEM reads, 2-entry
//            {pc,instr} output FIFO, redirect flush. Optional macro
//            IFETCH_BYPASS_EN forwards a returning word straight to out_*.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [3:0]  imem_wea,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;

  logic [31:0] target_pc;
  logic [31:0] issue_pc;
  logic        fifo_empty;
  logic        bypass;
  logic        pop;
  logic        fifo_pop;
  logic        push;
  logic        issue;
  logic [2:0]  pending;

  assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign issue_pc   = (redirect_valid && !rst) ? target_pc : fetch_pc_q;
  assign imem_addr  = issue_pc[13:2];
  assign imem_wea   = 4'b0000;
  assign fifo_empty = (count_q == 2'd0);

`ifdef IFETCH_BYPASS_EN
  // An empty FIFO lets the returning RAM word drive the outputs directly.
  assign bypass    = fifo_empty && inflight_q;
  assign out_valid = !fifo_empty || inflight_q;
  assign out_pc    = !fifo_empty ? pc0_q  : (inflight_q ? inflight_pc_q : 32'h0);
  assign out_instr = !fifo_empty ? ins0_q : (inflight_q ? imem_rdata    : 32'h0);
`else
  assign bypass    = 1'b0;
  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_empty ? 32'h0 : pc0_q;
  assign out_instr = fifo_empty ? 32'h0 : ins0_q;
`endif

  assign pop      = out_valid && out_ready;
  assign fifo_pop = pop && !fifo_empty;
  assign push     = inflight_q && !(bypass && out_ready);
  // Words stored plus words still coming back must never exceed the FIFO depth.
  assign pending  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue    = redirect_valid || (pending < 3'd2);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (issue) begin
      fetch_pc_d    = issue_pc + 32'd4;
      inflight_pc_d = issue_pc;
    end
  end

  always_comb begin
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    ins0_d  = ins0_q;
    ins1_d  = ins1_q;
    count_d = count_q;
    if (fifo_pop) begin
      pc0_d   = pc1_q;
      ins0_d  = ins1_q;
      count_d = count_q - 2'd1;
    end
    // A redirect drops both the stored words and the word returning now.
    if (redirect_valid) begin
      count_d = 2'd0;
    end else if (push) begin
      if (count_d == 2'd0) begin
        pc0_d  = inflight_pc_q;
        ins0_d = imem_rdata;
      end else begin
        pc1_d  = inflight_pc_q;
        ins1_d = imem_rdata;
      end
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= 2'd0;
      pc0_q         <= 32'h0;
      pc1_q         <= 32'h0;
      ins0_q        <= 32'h0;
      ins1_q        <= 32'h0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      pc0_q         <= pc0_d;
      pc1_q         <= pc1_d;
      ins0_q        <= ins0_d;
      ins1_q        <= ins1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit with a stream-level
//            model (next expected pc) and directed literal checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [31:0] TB_RESET_PC   = 32'h0000_0000;
  localparam logic [11:0] TB_RESET_WORD = TB_RESET_PC[13:2];
`ifdef IFETCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [3:0]  imem_wea;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  instr_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_wea       (imem_wea),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic        prev_hold;
  logic [31:0] acc_pc[$];
  logic [31:0] acc_ins[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Stream model: the accepted instruction sequence is consecutive words from
  // the last restart point, each instruction equal to the RAM contents.
  always @(negedge clk) begin
    chk("wea", {28'h0, imem_wea}, 32'h0);
    if (rst) begin
      chk("rst_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_addr", {20'h0, imem_addr}, {20'h0, TB_RESET_WORD});
      exp_pc    = TB_RESET_PC;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("hold_valid", {31'h0, out_valid}, 32'h1);
      if (out_valid) begin
        chk("model_pc", out_pc, exp_pc);
        chk("model_instr", out_instr, mem[exp_pc[13:2]]);
      end
      if (redirect_valid)
        chk("redir_addr", {20'h0, imem_addr}, {20'h0, redirect_pc[13:2]});
      if (out_valid && out_ready) begin
        acc_pc.push_back(out_pc);
        acc_ins.push_back(out_instr);
        exp_pc = exp_pc + 32'd4;
      end
      prev_hold = out_valid && !out_ready && !redirect_valid;
      if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = rdy;
    cyc(2);
    acc_pc.delete();
    acc_ins.delete();
    rst = 1'b0;
  endtask

  // Leaves the caller at the negedge of the first cycle with out_valid high.
  task automatic wait_first_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          n4;
    logic        found;
    logic [15:0] pat;

    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 + 32'(i) * 32'd17;
    mem[0]    = 32'h0800_4693;
    mem[1]    = 32'h0000_1137;
    mem[2]    = 32'h0000_4533;
    mem[4095] = 32'h0000_0073;

    rst            = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    cyc(3);
    @(negedge clk);
    chk("reset_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_addr", {20'h0, imem_addr}, 32'h0);

    // Basic stream after reset
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_first_valid(lat);
    chk("a_lat", 32'(lat), 32'(EXP_LAT));
    chk("a_pc0", out_pc, 32'h0);
    chk("a_ins0", out_instr, 32'h0800_4693);
    cyc(1);
    @(negedge clk);
    chk("a_valid1", {31'h0, out_valid}, 32'h1);
    chk("a_pc1", out_pc, 32'h4);
    chk("a_ins1", out_instr, 32'h0000_1137);
    cyc(1);
    @(negedge clk);
    chk("a_pc2", out_pc, 32'h8);
    chk("a_ins2", out_instr, 32'h0000_4533);

    // Back-pressure from the first word
    do_reset(1'b0);
    wait_first_valid(lat);
    chk("b_lat", 32'(lat), 32'(EXP_LAT));
    chk("b_pc", out_pc, 32'h0);
    for (int s = 1; s < 5; s++) begin
      cyc(1);
      @(negedge clk);
      chk("b_stall_pc", out_pc, 32'h0);
      chk("b_stall_ins", out_instr, 32'h0800_4693);
      chk("b_stall_addr", {20'h0, imem_addr}, 32'h2);
    end
    cyc(1);
    out_ready = 1'b1;
    cyc(6);
    chk("b_count", {31'h0, acc_pc.size() >= 4}, 32'h1);
    chk("b_acc0", acc_pc[0], 32'h0);
    chk("b_acc1", acc_pc[1], 32'h4);
    chk("b_acc2", acc_pc[2], 32'h8);
    chk("b_acc3", acc_pc[3], 32'hC);

    // Redirect while the FIFO is full
    out_ready = 1'b0;
    cyc(4);
    acc_pc.delete();
    acc_ins.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    @(negedge clk);
    chk("c_addr", {20'h0, imem_addr}, 32'h8);
    chk("c_full", {31'h0, out_valid}, 32'h1);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    wait_first_valid(lat);
    chk("c_lat", 32'(lat), 32'(EXP_LAT - 1));
    chk("c_pc", out_pc, 32'h20);
    cyc(4);
    chk("c_acc0", acc_pc[0], 32'h20);
    chk("c_acc1", acc_pc[1], 32'h24);

    // Redirect in the same cycle as a handshake on pc 4
    do_reset(1'b1);
    wait_first_valid(lat);
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(negedge clk);
    chk("d_valid", {31'h0, out_valid}, 32'h1);
    chk("d_pc", out_pc, 32'h4);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    cyc(6);
    chk("d_acc0", acc_pc[0], 32'h0);
    chk("d_acc1", acc_pc[1], 32'h4);
    chk("d_acc2", acc_pc[2], 32'h40);
    chk("d_acc3", acc_pc[3], 32'h44);
    n4 = 0;
    foreach (acc_pc[j]) if (acc_pc[j] == 32'h4) n4++;
    chk("d_once", 32'(n4), 32'h1);

    // Word-address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3FFC;
    @(negedge clk);
    chk("e_addr0", {20'h0, imem_addr}, 32'hFFF);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    acc_pc.delete();
    acc_ins.delete();
    @(negedge clk);
    chk("e_addr1", {20'h0, imem_addr}, 32'h0);
    cyc(5);
    chk("e_acc0", acc_pc[0], 32'h3FFC);
    chk("e_ins0", acc_ins[0], 32'h0000_0073);
    chk("e_acc1", acc_pc[1], 32'h4000);
    chk("e_ins1", acc_ins[1], 32'h0800_4693);

    // Reset mid-stream with a read in flight
    cyc(3);
    rst = 1'b1;
    @(negedge clk);
    chk("f_valid", {31'h0, out_valid}, 32'h0);
    cyc(2);
    acc_pc.delete();
    acc_ins.delete();
    rst = 1'b0;
    wait_first_valid(lat);
    chk("f_lat", 32'(lat), 32'(EXP_LAT));
    chk("f_pc", out_pc, TB_RESET_PC);

    // Mixed ready pattern with misaligned and wrapping redirects
    cyc(1);
    acc_pc.delete();
    acc_ins.delete();
    pat = 16'b1011_0010_1110_0110;
    for (int i = 0; i < 60; i++) begin
      out_ready      = pat[i % 16];
      redirect_valid = (i == 10) || (i == 30);
      redirect_pc    = (i == 10) ? 32'h0000_0103 : 32'h0000_3FF8;
      cyc(1);
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    cyc(8);
    found = 1'b0;
    foreach (acc_pc[j]) if (acc_pc[j] == 32'h100) found = 1'b1;
    chk("m_align", {31'h0, found}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
